// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider.
// The optional divide-by-zero flag is controlled by DIVIDER_DIV0_FLAG_EN (see divider.sv).
package divider_pkg;

  localparam int DIVIDER_N = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold the value n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_adder.sv
// Ripple-carry adder used by the divider as its trial subtractor (b pre-inverted, cin=1).
// Outputs are forced to zero while rst is high or en is low.
module adder #(
  parameter int W = 9
) (
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0]   w_carry;
  logic [W-1:0] w_sum;
  logic         w_active;

  assign w_carry[0] = cin;
  assign w_active   = en & ~rst;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign w_sum[gi]     = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign sum  = w_active ? w_sum : '0;
  assign cout = w_active & w_carry[W];

endmodule

// File: rtl/divider.sv
// Unsigned restoring divider, one quotient bit per enabled cycle, MSB first.
// Define DIVIDER_DIV0_FLAG_EN to add the div_by_zero port and the single-cycle zero-divisor path.
module divider
  import divider_pkg::*;
#(
  parameter int n = DIVIDER_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         start,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         busy,
  output logic         done
`ifdef DIVIDER_DIV0_FLAG_EN
  ,
  output logic         div_by_zero
`endif
);

  localparam int CW = cnt_width(n);

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_count, w_count_next;
  logic [n:0]     r_prem, w_prem_next;
  logic [n-1:0]   r_dvd, w_dvd_next;
  logic [n-1:0]   r_dvs, w_dvs_next;
  logic [n-1:0]   r_quot, w_quot_next;
  logic [n-1:0]   r_rem, w_rem_next;
  logic           r_div0, w_div0_next;

  logic [2*n:0]   w_pair;
  logic [n:0]     w_shift;
  logic [n:0]     w_dvs_inv;
  logic [n:0]     w_sum;
  logic           w_cout;

  // {partial remainder, dividend} shifted as one register pair; the dividend
  // half collects quotient bits in its LSB as the old bits move out the top.
  assign w_pair    = {r_prem, r_dvd} << 1;
  assign w_shift   = w_pair[2*n:n];
  assign w_dvs_inv = ~{1'b0, r_dvs};

  adder #(.W(n + 1)) u_sub (
    .rst  (rst),
    .en   (1'b1),
    .a    (w_shift),
    .b    (w_dvs_inv),
    .cin  (1'b1),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_prem_next  = r_prem;
    w_dvd_next   = r_dvd;
    w_dvs_next   = r_dvs;
    w_quot_next  = r_quot;
    w_rem_next   = r_rem;
    w_div0_next  = r_div0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_dvd_next   = dividend;
          w_dvs_next   = divisor;
          w_prem_next  = '0;
          w_count_next = CW'(n);
          w_state_next = CALC;
`ifdef DIVIDER_DIV0_FLAG_EN
          w_div0_next  = 1'b0;
          if (divisor == '0) begin
            w_div0_next  = 1'b1;
            w_quot_next  = '1;
            w_rem_next   = dividend;
            w_count_next = '0;
            w_state_next = DONE;
          end
`endif
        end
      end
      CALC: begin
        // cout=1 means no borrow: keep the difference, quotient bit 1.
        w_prem_next  = w_cout ? w_sum : w_shift;
        w_dvd_next   = w_pair[n-1:0] | {{(n-1){1'b0}}, w_cout};
        w_count_next = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_next = DONE;
          w_quot_next  = w_dvd_next;
          w_rem_next   = w_prem_next[n-1:0];
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_prem  <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div0  <= 1'b0;
    end else if (en) begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_prem  <= w_prem_next;
      r_dvd   <= w_dvd_next;
      r_dvs   <= w_dvs_next;
      r_quot  <= w_quot_next;
      r_rem   <= w_rem_next;
      r_div0  <= w_div0_next;
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

`ifdef DIVIDER_DIV0_FLAG_EN
  assign div_by_zero = r_div0;
`else
  // Only the flag path reads r_div0; keep it tied off so nothing dangles.
  logic w_div0_unused;
  assign w_div0_unused = r_div0;
`endif

endmodule

// File: tb/tb_divider.sv
// Randomized self-checking bench for divider against a plain-arithmetic model.
module tb_divider;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
`ifdef DIVIDER_DIV0_FLAG_EN
  logic         div_by_zero;
`endif

  int n_checks = 0;
  int n_errors = 0;

  divider #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
`ifdef DIVIDER_DIV0_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ref_model(input int a, input int b, output int q, output int r, output int lat);
    if (b == 0) begin
      q = (1 << N) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
`ifdef DIVIDER_DIV0_FLAG_EN
    lat = (b == 0) ? 1 : N + 1;
`else
    lat = N + 1;
`endif
  endtask

  // One division; edges counted with the start edge as edge 1.
  task automatic do_div(input int a, input int b, input int stall_at, input int stall_len,
                        input bit poke, input bit hold_done, input string tag);
    int edges;
    int eq, er, lat;
    ref_model(a, b, eq, er, lat);
    if (stall_at > 0) lat += stall_len;
    dividend = N'(a);
    divisor  = N'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 200) begin
      if (stall_at > 0 && edges == stall_at) en = 1'b0;
      if (stall_at > 0 && edges == stall_at + stall_len) en = 1'b1;
      if (poke && edges == 3) begin
        start = 1'b1; dividend = 9; divisor = 3;
      end else if (poke && edges == 4) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (!en) check({tag, "_stall_busy"}, {31'd0, busy & ~done}, 1);
    end
    start = 1'b0;
    en    = 1'b1;
    check({tag, "_lat"}, edges, lat);
    check({tag, "_q"}, {24'd0, quotient}, eq);
    check({tag, "_r"}, {24'd0, remainder}, er);
`ifdef DIVIDER_DIV0_FLAG_EN
    check({tag, "_div0"}, {31'd0, div_by_zero}, (b == 0) ? 1 : 0);
`endif
    if (hold_done) begin
      en = 1'b0;
      repeat (2) begin
        @(posedge clk); #1;
        check({tag, "_hold_done"}, {31'd0, done}, 1);
      end
      en = 1'b1;
    end
    // Start during DONE must be ignored: the next edge returns to IDLE.
    start = 1'b1; dividend = 1; divisor = 1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_done_start_ign"}, {30'd0, busy, done}, 0);
    check({tag, "_q_hold"}, {24'd0, quotient}, eq);
    $display("div %0d/%0d -> q=%0d r=%0d latency=%0d", a, b, quotient, remainder, edges);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_q", {24'd0, quotient}, 0);
    check("reset_r", {24'd0, remainder}, 0);
    check("reset_busy_done", {30'd0, busy, done}, 0);
`ifdef DIVIDER_DIV0_FLAG_EN
    check("reset_div0", {31'd0, div_by_zero}, 0);
`endif

    do_div(100, 7, 0, 0, 0, 1, "norm");
    do_div(255, 1, 0, 0, 0, 0, "b255_1");
    do_div(0, 5, 0, 0, 0, 0, "b0_5");
    do_div(5, 200, 0, 0, 0, 0, "b5_200");
    do_div(255, 255, 0, 0, 0, 0, "b255_255");
    do_div(77, 0, 0, 0, 0, 0, "div0");
    do_div(100, 7, 4, 3, 0, 0, "stall");
    do_div(100, 7, 0, 0, 1, 0, "poke");

    // Reset in the middle of CALC aborts the operation silently.
    dividend = 100; divisor = 7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 0);
    check("rst_mid_q", {24'd0, quotient}, 0);
    check("rst_mid_r", {24'd0, remainder}, 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("rst_mid_no_done", pulses, 0);
    do_div(50, 6, 0, 0, 0, 0, "after_rst");

    for (int i = 0; i < 40; i++) begin
      int a, b;
      a = int'($urandom_range(0, (1 << N) - 1));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, (1 << N) - 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_div(a, b, ($urandom_range(0, 3) == 0) ? 2 : 0, int'($urandom_range(1, 3)), 0, 0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
